cpu_bus_responder: RTL

- Responder side of the CPU memory bus. Decodes every CPU address/write cycle and returns read data on the CPU data-in bus.
- Holds the 2 KiB internal work RAM (mirrored). Forwards PPU register accesses, passes PRG-ROM reads to the cartridge port, and runs the $4014 OAM DMA engine.
- The DMA engine stalls the CPU through cpu_rdy. It sits between the cpu module and the PPU/cartridge.

---
 rtl/cpu_bus_responder_if.sv | 26 ++
 rtl/cpu_bus_responder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cpu_bus_responder_if.sv
// CPU-side memory bus plus the PPU register and cartridge PRG ports seen by the responder.
interface cpu_bus_responder_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic [2:0]  ppu_addr;
  logic [7:0]  ppu_wdata;
  logic        ppu_we;
  logic        ppu_re;
  logic [7:0]  ppu_rdata;
  logic [14:0] prg_addr;
  logic [7:0]  prg_rdata;
  logic        dma_active;

  modport slave (
    input  cpu_addr, cpu_dout, cpu_we, ppu_rdata, prg_rdata,
    output cpu_din, cpu_rdy, ppu_addr, ppu_wdata, ppu_we, ppu_re, prg_addr, dma_active
  );

  modport master (
    output cpu_addr, cpu_dout, cpu_we, ppu_rdata, prg_rdata,
    input  cpu_din, cpu_rdy, ppu_addr, ppu_wdata, ppu_we, ppu_re, prg_addr, dma_active
  );
endinterface

// File: rtl/cpu_bus_responder.sv
// CPU bus responder: mirrored work RAM, PPU register forwarding, PRG reads, open bus and the
// $4014 OAM DMA engine that stalls the CPU through cpu_rdy.
module cpu_bus_responder #(
  parameter int unsigned RAM_AW   = 11,
  parameter logic [2:0]  OAM_PORT = 3'd4
) (
  input logic                clk,
  input logic                rst,
  cpu_bus_responder_if.slave bus
);

  localparam int unsigned RamDepth = 1 << RAM_AW;

  typedef enum logic [2:0] {
    StIdle,
    StDummy,
    StAlign,
    StRd,
    StWr
  } dma_state_e;

  dma_state_e r_state;
  dma_state_e w_state_next;

  logic       r_parity;
  logic [7:0] r_page;
  logic [7:0] r_idx;
  logic [7:0] r_dma_data;
  logic [7:0] r_cpu_din;
  logic [7:0] r_open_bus;
  logic [7:0] r_ram [RamDepth];

  logic        w_rdy;
  logic        w_dma_rd;
  logic        w_dma_wr;
  logic        w_cpu_cycle;
  logic        w_cpu_rd;
  logic        w_cpu_wr;
  logic        w_dma_start;
  logic [15:0] w_addr;
  logic        w_sel_ram;
  logic        w_sel_ppu;
  logic        w_sel_prg;
  logic [7:0]  w_rd_data;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state and state-derived controls
  always_comb begin
    w_state_next = r_state;
    w_rdy        = 1'b0;
    w_dma_rd     = 1'b0;
    w_dma_wr     = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_rdy = 1'b1;
        if (w_dma_start) begin
          w_state_next = StDummy;
        end
      end
      StDummy: begin
        w_state_next = r_parity ? StAlign : StRd;
      end
      StAlign: begin
        w_state_next = StRd;
      end
      StRd: begin
        w_dma_rd     = 1'b1;
        w_state_next = StWr;
      end
      StWr: begin
        w_dma_wr     = 1'b1;
        w_state_next = (r_idx == 8'hFF) ? StIdle : StRd;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Address decode; the DMA read borrows the same path with the page/index as its address.
  always_comb begin
    w_cpu_cycle = w_rdy && !rst;
    w_cpu_rd    = w_cpu_cycle && !bus.cpu_we;
    w_cpu_wr    = w_cpu_cycle && bus.cpu_we;
    w_addr      = w_dma_rd ? {r_page, r_idx} : bus.cpu_addr;
    w_sel_ram   = (w_addr[15:13] == 3'b000);
    w_sel_ppu   = (w_addr[15:13] == 3'b001);
    w_sel_prg   = w_addr[15];
    w_dma_start = w_cpu_wr && (w_addr == 16'h4014);

    if (w_sel_ram) begin
      w_rd_data = r_ram[w_addr[RAM_AW-1:0]];
    end else if (w_sel_ppu) begin
      w_rd_data = bus.ppu_rdata;
    end else if (w_sel_prg) begin
      w_rd_data = bus.prg_rdata;
    end else begin
      w_rd_data = r_open_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (w_cpu_wr && w_sel_ram) begin
      r_ram[w_addr[RAM_AW-1:0]] <= bus.cpu_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity   <= 1'b0;
      r_cpu_din  <= 8'h00;
      r_open_bus <= 8'h00;
      r_page     <= 8'h00;
      r_idx      <= 8'h00;
      r_dma_data <= 8'h00;
    end else begin
      r_parity <= ~r_parity;
      if (w_cpu_rd) begin
        r_cpu_din  <= w_rd_data;
        r_open_bus <= w_rd_data;
      end
      if (w_dma_start) begin
        r_page <= bus.cpu_dout;
        r_idx  <= 8'h00;
      end else if (w_dma_wr) begin
        r_idx <= r_idx + 8'd1;
      end
      if (w_dma_rd) begin
        r_dma_data <= w_rd_data;
      end
    end
  end

  assign bus.cpu_din    = r_cpu_din;
  assign bus.cpu_rdy    = w_rdy;
  assign bus.dma_active = !w_rdy;
  assign bus.prg_addr   = w_addr[14:0];
  assign bus.ppu_addr   = w_dma_wr ? OAM_PORT : w_addr[2:0];
  assign bus.ppu_wdata  = w_dma_wr ? r_dma_data : bus.cpu_dout;
  assign bus.ppu_we     = (w_cpu_wr && w_sel_ppu) || (w_dma_wr && !rst);
  assign bus.ppu_re     = (w_cpu_rd || (w_dma_rd && !rst)) && w_sel_ppu;

  a_no_dual_strobe: assert property (@(posedge clk) disable iff (rst)
    !(bus.ppu_we && bus.ppu_re));

endmodule
